// File: rtl/rvsteel_spi_multi.sv
// rvsteel_spi_multi: SPI master with multiple chip selects, runtime mode/rate.
// Define SPI_LSB_FIRST_EN to add the lsb_first port (LSB-first ordering).
module rvsteel_spi_multi #(
   parameter int DATA_WIDTH      = 8,
   parameter int NUM_CS_LINES    = 1,
   parameter int CLOCK_DIV_WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       cpol,
   input  logic                       cpha,
   input  logic [CLOCK_DIV_WIDTH-1:0] clk_div,
   input  logic [NUM_CS_LINES-1:0]    cs_mask,
   input  logic                       hold_cs,
`ifdef SPI_LSB_FIRST_EN
   input  logic                       lsb_first,
`endif
   input  logic                       tx_valid,
   output logic                       tx_ready,
   input  logic [DATA_WIDTH-1:0]      tx_data,
   output logic                       rx_valid,
   output logic [DATA_WIDTH-1:0]      rx_data,
   output logic                       busy,
   output logic                       sclk,
   output logic                       pico,
   input  logic                       poci,
   output logic [NUM_CS_LINES-1:0]    cs
);

   localparam int EW = $clog2(2 * DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      CS_KEEP
   } state_t;

   state_t                     state;
   logic [CLOCK_DIV_WIDTH-1:0] div_q;
   logic [CLOCK_DIV_WIDTH-1:0] cnt;
   logic [EW-1:0]              edge_cnt;
   logic                       cpol_q;
   logic                       cpha_q;
   logic                       hold_q;
   logic                       lsb_q;
   logic                       lsb_in;
   logic [DATA_WIDTH-1:0]      txd;
   logic [DATA_WIDTH-1:0]      rxs;
   logic                       accept;
   logic                       cnt_done;
   logic                       last_edge;
   logic                       sample_edge;

`ifdef SPI_LSB_FIRST_EN
   assign lsb_in = lsb_first;
`else
   assign lsb_in = 1'b0;
`endif

   assign accept    = tx_valid && tx_ready;
   assign cnt_done  = (cnt == div_q);
   assign last_edge = (edge_cnt == EW'(2 * DATA_WIDTH - 1));
   // even edges lead, odd edges trail; cpha picks which one samples
   assign sample_edge = ~edge_cnt[0] ^ cpha_q;

   function automatic logic head(
      input logic [DATA_WIDTH-1:0] d,
      input logic                  lsb
   );
      return lsb ? d[0] : d[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] advance(
      input logic [DATA_WIDTH-1:0] d,
      input logic                  lsb
   );
      return lsb ? (d >> 1) : (d << 1);
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cs       <= '1;
         sclk     <= 1'b0;
         pico     <= 1'b0;
         tx_ready <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         busy     <= 1'b0;
         div_q    <= '0;
         cnt      <= '0;
         edge_cnt <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         hold_q   <= 1'b0;
         lsb_q    <= 1'b0;
         txd      <= '0;
         rxs      <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (accept) begin
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            div_q    <= clk_div;
            hold_q   <= hold_cs;
            lsb_q    <= lsb_in;
            sclk     <= cpol;
            cnt      <= '0;
            edge_cnt <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               sclk <= cpol;
               if (accept) begin
                  txd   <= tx_data;
                  cs    <= ~cs_mask;
                  state <= CS_SETUP;
               end else begin
                  tx_ready <= 1'b1;
               end
            end
            CS_SETUP: begin
               if (cnt_done) begin
                  cnt      <= '0;
                  edge_cnt <= '0;
                  state    <= SHIFT;
                  if (!cpha_q) begin
                     pico <= head(txd, lsb_q);
                     txd  <= advance(txd, lsb_q);
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt_done) begin
                  cnt      <= '0;
                  edge_cnt <= edge_cnt + 1'b1;
                  sclk     <= ~sclk;
                  if (sample_edge) begin
                     rxs <= lsb_q ? {poci, rxs[DATA_WIDTH-1:1]}
                                  : {rxs[DATA_WIDTH-2:0], poci};
                  end else begin
                     pico <= head(txd, lsb_q);
                     txd  <= advance(txd, lsb_q);
                  end
                  if (last_edge) state <= CS_HOLD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CS_HOLD: begin
               if (cnt_done) begin
                  cnt      <= '0;
                  rx_valid <= 1'b1;
                  rx_data  <= rxs;
                  tx_ready <= 1'b1;
                  if (hold_q) begin
                     state <= CS_KEEP;
                  end else begin
                     state <= IDLE;
                     cs    <= '1;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CS_KEEP: begin
               if (accept) begin
                  state <= SHIFT;
                  if (!cpha) begin
                     pico <= head(tx_data, lsb_in);
                     txd  <= advance(tx_data, lsb_in);
                  end else begin
                     txd <= tx_data;
                  end
               end else begin
                  state <= IDLE;
                  cs    <= '1;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
